// File: rtl/apb_gpio_banked_pkg.sv
// ----------------------------------------------------------------------------
// apb_gpio_banked_pkg
// Shared definitions for the banked APB GPIO controller:
//   - word indices of the per-bank registers (byte offset = index * 4)
//   - inttype_e: interrupt trigger type encoded as {INTTYPE1, INTTYPE0}
//   - num_banks(): number of 32-pin banks needed for a pin count
//   - pin_event(): per-pin trigger condition for a given type
// ----------------------------------------------------------------------------
package apb_gpio_banked_pkg;

  localparam int BANK_PINS = 32;

  // Register word indices within a bank (PADDR[5:2]).
  localparam logic [3:0] REG_DIR      = 4'd0;   // 0x00
  localparam logic [3:0] REG_IN       = 4'd1;   // 0x04 read-only
  localparam logic [3:0] REG_OUT      = 4'd2;   // 0x08
  localparam logic [3:0] REG_OUTSET   = 4'd3;   // 0x0C write-only
  localparam logic [3:0] REG_OUTCLR   = 4'd4;   // 0x10 write-only
  localparam logic [3:0] REG_OUTTOG   = 4'd5;   // 0x14 write-only
  localparam logic [3:0] REG_INTEN    = 4'd6;   // 0x18
  localparam logic [3:0] REG_INTTYPE0 = 4'd7;   // 0x1C
  localparam logic [3:0] REG_INTTYPE1 = 4'd8;   // 0x20
  localparam logic [3:0] REG_STATUS   = 4'd9;   // 0x24 W1C
  localparam logic [3:0] REG_GPIOEN   = 4'd10;  // 0x28
  localparam logic [3:0] REG_DBEN     = 4'd11;  // 0x2C
  localparam logic [3:0] REG_DBPRESC  = 4'd12;  // 0x30, bank 0 only

  typedef enum logic [1:0] {
    LEV_HI = 2'b00,
    LEV_LO = 2'b01,
    RISE   = 2'b10,
    FALL   = 2'b11
  } inttype_e;

  function automatic int num_banks(input int n);
    return (n + BANK_PINS - 1) / BANK_PINS;
  endfunction

  // cur is the (filtered) synchronised level, prev its value one cycle earlier.
  function automatic logic pin_event(input inttype_e t, input logic cur, input logic prev);
    case (t)
      LEV_HI:  return cur;
      LEV_LO:  return ~cur;
      RISE:    return cur & ~prev;
      default: return ~cur & prev;
    endcase
  endfunction

endpackage

// File: rtl/apb_gpio_banked_if.sv
// ----------------------------------------------------------------------------
// apb_gpio_banked_if
// APB3 slave bus bundle for the banked GPIO controller.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave  -> master
// ----------------------------------------------------------------------------
interface apb_gpio_banked_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_banked_bank.sv
// ----------------------------------------------------------------------------
// apb_gpio_banked_bank
// One bank of up to 32 GPIO pins: configuration registers, output register
// with atomic set/clear/toggle, 2-flop input synchroniser, optional debounce
// filter, edge/level detection and sticky W1C interrupt status.
// Optional feature macro: APB_GPIO_BANKED_DEBOUNCE_EN (adds DBEN register and
// per-pin debounce filter driven by i_db_tick).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_wr_en           validated, error-free write strobe targeting this bank
//   i_reg             register word index (PADDR[5:2])
//   i_wdata           write data, W bits
//   i_db_tick         debounce sample tick from the global prescaler
//   i_gpio_in         asynchronous pad inputs for this bank
//   o_rdata           combinational read data for i_reg (zero-extended)
//   o_gpio_out/dir    output value / direction
//   o_gpio_in_sync    synchronised (and filtered) input
//   o_irq             |(STATUS & INTEN)
// ----------------------------------------------------------------------------
module apb_gpio_banked_bank
  import apb_gpio_banked_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [3:0]   i_reg,
  input  logic [W-1:0] i_wdata,
  input  logic         i_db_tick,
  input  logic [W-1:0] i_gpio_in,
  output logic [31:0]  o_rdata,
  output logic [W-1:0] o_gpio_out,
  output logic [W-1:0] o_gpio_dir,
  output logic [W-1:0] o_gpio_in_sync,
  output logic         o_irq
);

  logic [W-1:0] r_dir;
  logic [W-1:0] r_out;
  logic [W-1:0] r_inten;
  logic [W-1:0] r_type0;
  logic [W-1:0] r_type1;
  logic [W-1:0] r_status;
  logic [W-1:0] r_gpioen;
  logic [W-1:0] r_sync0;
  logic [W-1:0] r_sync1;
  logic [W-1:0] r_prev;

  logic [W-1:0] w_filt;
  logic [W-1:0] w_event;
  logic [W-1:0] w_w1c;

  assign w_w1c = (i_wr_en && i_reg == REG_STATUS) ? i_wdata : '0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_det
      assign w_event[gi] = r_gpioen[gi] &
                           pin_event(inttype_e'({r_type1[gi], r_type0[gi]}), w_filt[gi], r_prev[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir    <= '0;
      r_out    <= '0;
      r_inten  <= '0;
      r_type0  <= '0;
      r_type1  <= '0;
      r_status <= '0;
      r_gpioen <= '0;
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_prev   <= '0;
    end else begin
      if (i_wr_en) begin
        case (i_reg)
          REG_DIR:      r_dir   <= i_wdata;
          REG_OUT:      r_out   <= i_wdata;
          REG_OUTSET:   r_out   <= r_out | i_wdata;
          REG_OUTCLR:   r_out   <= r_out & ~i_wdata;
          REG_OUTTOG:   r_out   <= r_out ^ i_wdata;
          REG_INTEN:    r_inten <= i_wdata;
          REG_INTTYPE0: r_type0 <= i_wdata;
          REG_INTTYPE1: r_type1 <= i_wdata;
          REG_GPIOEN:   r_gpioen <= i_wdata;
          default: ;
        endcase
      end
      // A set event in the same cycle as a W1C wins, so no event is lost.
      r_status <= (r_status & ~w_w1c) | w_event;
      // Disabled pins freeze their whole input chain.
      r_sync0  <= (r_sync0 & ~r_gpioen) | (i_gpio_in & r_gpioen);
      r_sync1  <= (r_sync1 & ~r_gpioen) | (r_sync0 & r_gpioen);
      r_prev   <= (r_prev  & ~r_gpioen) | (w_filt  & r_gpioen);
    end
  end

`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
  logic [W-1:0] r_dben;
  logic [W-1:0] r_filt;
  logic [1:0]   r_db_cnt [W];

  // While DBEN=0 the filter shadows sync1 so enabling it causes no glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dben <= '0;
      r_filt <= '0;
      for (int i = 0; i < W; i++) r_db_cnt[i] <= 2'd0;
    end else begin
      if (i_wr_en && i_reg == REG_DBEN) r_dben <= i_wdata;
      for (int i = 0; i < W; i++) begin
        if (!r_dben[i]) begin
          r_filt[i]   <= r_sync1[i];
          r_db_cnt[i] <= 2'd0;
        end else if (r_gpioen[i] && i_db_tick) begin
          if (r_sync1[i] == r_filt[i]) begin
            r_db_cnt[i] <= 2'd0;
          end else if (r_db_cnt[i] == 2'd2) begin
            // third consecutive disagreeing tick
            r_filt[i]   <= r_sync1[i];
            r_db_cnt[i] <= 2'd0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 2'd1;
          end
        end
      end
    end
  end

  assign w_filt = (r_filt & r_dben) | (r_sync1 & ~r_dben);
`else
  logic w_unused_tick;
  assign w_unused_tick = i_db_tick;
  assign w_filt = r_sync1;
`endif

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_DIR:      o_rdata = 32'(r_dir);
      REG_IN:       o_rdata = 32'(w_filt);
      REG_OUT:      o_rdata = 32'(r_out);
      REG_INTEN:    o_rdata = 32'(r_inten);
      REG_INTTYPE0: o_rdata = 32'(r_type0);
      REG_INTTYPE1: o_rdata = 32'(r_type1);
      REG_STATUS:   o_rdata = 32'(r_status);
      REG_GPIOEN:   o_rdata = 32'(r_gpioen);
`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
      REG_DBEN:     o_rdata = 32'(r_dben);
`endif
      default:      o_rdata = '0;
    endcase
  end

  assign o_gpio_out     = r_out;
  assign o_gpio_dir     = r_dir;
  assign o_gpio_in_sync = w_filt;
  assign o_irq          = |(r_status & r_inten);

endmodule

// File: rtl/apb_gpio_banked.sv
// ----------------------------------------------------------------------------
// apb_gpio_banked
// APB GPIO controller for NUM_GPIO pins in 32-pin banks. Holds the address
// decode, error generation, read-data mux, global debounce prescaler and the
// interrupt OR; per-bank logic lives in apb_gpio_banked_bank.
// Optional feature macro: APB_GPIO_BANKED_DEBOUNCE_EN (DBEN/DBPRESC registers,
// prescaler and input debounce). Without it DBEN/DBPRESC are unmapped.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   apb             APB slave (PADDR bank=[AW-1:6], reg=[5:2]; PREADY tied 1)
//   gpio_in         asynchronous pad inputs
//   gpio_in_sync    synchronised (and filtered) inputs
//   gpio_out        output values
//   gpio_dir        direction, 1 = output
//   irq_bank        per-bank |(STATUS & INTEN)
//   interrupt       OR of irq_bank
// ----------------------------------------------------------------------------
module apb_gpio_banked
  import apb_gpio_banked_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 64,
  parameter int DB_CNT_W       = 16,
  localparam int NUM_BANKS     = num_banks(NUM_GPIO)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  apb_gpio_banked_if.slave     apb,
  input  logic [NUM_GPIO-1:0]  gpio_in,
  output logic [NUM_GPIO-1:0]  gpio_in_sync,
  output logic [NUM_GPIO-1:0]  gpio_out,
  output logic [NUM_GPIO-1:0]  gpio_dir,
  output logic [NUM_BANKS-1:0] irq_bank,
  output logic                 interrupt
);

  localparam int BANK_AW = APB_ADDR_WIDTH - 6;

`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [BANK_AW-1:0] w_bank;
  logic [3:0]         w_reg;
  logic               w_access;
  logic               w_bank_ok;
  logic               w_reg_ok;
  logic               w_err;
  logic               w_wr_ok;
  logic               w_db_tick;
  logic [31:0]        w_presc_rdata;
  logic [31:0]        w_sel_rdata;
  logic [31:0]        w_bank_rdata [NUM_BANKS];
  logic               w_unused_addr;

  assign w_bank        = apb.PADDR[APB_ADDR_WIDTH-1:6];
  assign w_reg         = apb.PADDR[5:2];
  assign w_unused_addr = ^apb.PADDR[1:0];
  assign w_access      = apb.PSEL & apb.PENABLE;
  assign w_bank_ok     = (w_bank < BANK_AW'(NUM_BANKS));

  always_comb begin
    w_reg_ok = 1'b0;
    case (w_reg)
      REG_DIR, REG_IN, REG_OUT, REG_OUTSET, REG_OUTCLR, REG_OUTTOG,
      REG_INTEN, REG_INTTYPE0, REG_INTTYPE1, REG_STATUS, REG_GPIOEN:
                   w_reg_ok = 1'b1;
      REG_DBEN:    w_reg_ok = DB_EN;
      REG_DBPRESC: w_reg_ok = DB_EN && (w_bank == '0);
      default:     w_reg_ok = 1'b0;
    endcase
  end

  // Decode error is address-only except for the read-only IN register.
  assign w_err   = ~w_bank_ok | ~w_reg_ok | (apb.PWRITE & (w_reg == REG_IN));
  assign w_wr_ok = w_access & apb.PWRITE & ~w_err;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_access & w_err;

`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] r_dbpresc;
  logic [DB_CNT_W-1:0] r_presc_cnt;

  // Counts 0..DBPRESC; a DBPRESC write restarts the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dbpresc   <= '0;
      r_presc_cnt <= '0;
    end else if (w_wr_ok && w_reg == REG_DBPRESC) begin
      r_dbpresc   <= apb.PWDATA[DB_CNT_W-1:0];
      r_presc_cnt <= '0;
    end else if (w_db_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  assign w_db_tick     = (r_presc_cnt == r_dbpresc);
  assign w_presc_rdata = 32'(r_dbpresc);
`else
  assign w_db_tick     = 1'b0;
  assign w_presc_rdata = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      // The last bank may be partial; its missing pins simply do not exist.
      localparam int W = (gi == NUM_BANKS - 1) ? (NUM_GPIO - gi * BANK_PINS) : BANK_PINS;
      logic w_bank_wr;
      assign w_bank_wr = w_wr_ok & (w_bank == BANK_AW'(gi));

      apb_gpio_banked_bank #(.W(W)) u_bank (
        .clk            (HCLK),
        .rst_n          (HRESETn),
        .i_wr_en        (w_bank_wr),
        .i_reg          (w_reg),
        .i_wdata        (apb.PWDATA[W-1:0]),
        .i_db_tick      (w_db_tick),
        .i_gpio_in      (gpio_in[gi*BANK_PINS +: W]),
        .o_rdata        (w_bank_rdata[gi]),
        .o_gpio_out     (gpio_out[gi*BANK_PINS +: W]),
        .o_gpio_dir     (gpio_dir[gi*BANK_PINS +: W]),
        .o_gpio_in_sync (gpio_in_sync[gi*BANK_PINS +: W]),
        .o_irq          (irq_bank[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sel_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bank == BANK_AW'(b)) w_sel_rdata = w_bank_rdata[b];
    end
  end

  assign apb.PRDATA = w_err                   ? 32'h0 :
                      (w_reg == REG_DBPRESC)  ? w_presc_rdata :
                                                w_sel_rdata;

  assign interrupt = |irq_bank;

endmodule

// File: tb/tb_apb_gpio_banked.sv
// ----------------------------------------------------------------------------
// tb_apb_gpio_banked
// Directed, table-driven bench for apb_gpio_banked with NUM_GPIO=40 (2 banks).
// ----------------------------------------------------------------------------
module tb_apb_gpio_banked;

  localparam int NG = 40;
  localparam int NB = 2;
  localparam int NV = 22;

`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic          HCLK;
  logic          HRESETn;
  logic [NG-1:0] gpio_in;
  logic [NG-1:0] gpio_in_sync;
  logic [NG-1:0] gpio_out;
  logic [NG-1:0] gpio_dir;
  logic [NB-1:0] irq_bank;
  logic          interrupt;

  apb_gpio_banked_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_gpio_banked #(
    .APB_ADDR_WIDTH (12),
    .NUM_GPIO       (NG),
    .DB_CNT_W       (16)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .apb          (bus),
    .gpio_in      (gpio_in),
    .gpio_in_sync (gpio_in_sync),
    .gpio_out     (gpio_out),
    .gpio_dir     (gpio_dir),
    .irq_bank     (irq_bank),
    .interrupt    (interrupt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_rd;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Two-phase APB transfer; returns at posedge+1 after the access phase.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge HCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    #1;
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge HCLK);
    #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    $display("TXN %s addr=0x%03h wdata=0x%08h rdata=0x%08h slverr=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] d);
    logic [31:0] rd;
    logic        e;
    apb_xfer(1'b1, addr, d, rd, e);
    check($sformatf("wr_err_%03h", addr), {31'b0, e}, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    apb_xfer(1'b0, addr, 32'h0, rd, e);
    check(name, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;

    //            wr    addr     wdata         exp_rdata     err        chk_rd
    vecs[0]  = '{1'b1, 12'h040, 32'hFFFF_FFFF, 32'h0,        1'b0,      1'b0};
    vecs[1]  = '{1'b0, 12'h040, 32'h0,         32'h0000_00FF, 1'b0,     1'b1};
    vecs[2]  = '{1'b1, 12'h048, 32'h0000_00A5, 32'h0,        1'b0,      1'b0};
    vecs[3]  = '{1'b0, 12'h048, 32'h0,         32'h0000_00A5, 1'b0,     1'b1};
    vecs[4]  = '{1'b1, 12'h04C, 32'h0000_0100, 32'h0,        1'b0,      1'b0};
    vecs[5]  = '{1'b0, 12'h048, 32'h0,         32'h0000_00A5, 1'b0,     1'b1};
    vecs[6]  = '{1'b1, 12'h050, 32'h0000_0001, 32'h0,        1'b0,      1'b0};
    vecs[7]  = '{1'b0, 12'h048, 32'h0,         32'h0000_00A4, 1'b0,     1'b1};
    vecs[8]  = '{1'b1, 12'h054, 32'h0000_000F, 32'h0,        1'b0,      1'b0};
    vecs[9]  = '{1'b0, 12'h048, 32'h0,         32'h0000_00AB, 1'b0,     1'b1};
    vecs[10] = '{1'b0, 12'h04C, 32'h0,         32'h0,        1'b0,      1'b1};
    vecs[11] = '{1'b0, 12'h080, 32'h0,         32'h0,        1'b1,      1'b1};
    vecs[12] = '{1'b0, 12'h034, 32'h0,         32'h0,        1'b1,      1'b1};
    vecs[13] = '{1'b1, 12'h004, 32'h0000_FFFF, 32'h0,        1'b1,      1'b1};
    vecs[14] = '{1'b0, 12'h004, 32'h0,         32'h0,        1'b0,      1'b1};
    vecs[15] = '{1'b0, 12'h02C, 32'h0,         32'h0,        !DB_EN,    1'b1};
    vecs[16] = '{1'b0, 12'h070, 32'h0,         32'h0,        1'b1,      1'b1};
    vecs[17] = '{1'b1, 12'h000, 32'h1234_5678, 32'h0,        1'b0,      1'b0};
    vecs[18] = '{1'b0, 12'h000, 32'h0,         32'h1234_5678, 1'b0,     1'b1};
    vecs[19] = '{1'b1, 12'h088, 32'hDEAD_BEEF, 32'h0,        1'b1,      1'b1};
    vecs[20] = '{1'b0, 12'h064, 32'h0,         32'h0,        1'b0,      1'b1};
    vecs[21] = '{1'b1, 12'h07C, 32'h0000_0001, 32'h0,        1'b1,      1'b1};

    // ---------------- reset state ----------------
    HRESETn     = 1'b0;
    gpio_in     = '0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 12'h040;
    bus.PWDATA  = 32'h0;
    repeat (3) @(negedge HCLK);
    check("rst_gpio_out_lo", gpio_out[31:0], 32'h0);
    check("rst_gpio_out_hi", {24'h0, gpio_out[39:32]}, 32'h0);
    check("rst_gpio_dir",    gpio_dir[31:0], 32'h0);
    check("rst_in_sync",     gpio_in_sync[31:0], 32'h0);
    check("rst_irq",         {29'h0, irq_bank, interrupt}, 32'h0);
    check("rst_pready",      {31'h0, bus.PREADY}, 32'h1);
    check("rst_prdata",      bus.PRDATA, 32'h0);
    HRESETn = 1'b1;

    // ---------------- register table ----------------
    for (int i = 0; i < NV; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e);
      check($sformatf("v%0d_slverr", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
    end
    check("pin_out_hi", {24'h0, gpio_out[39:32]}, 32'h0000_00AB);
    check("pin_out_lo", gpio_out[31:0], 32'h0);
    check("pin_dir_hi", {24'h0, gpio_dir[39:32]}, 32'h0000_00FF);
    check("pin_dir_lo", gpio_dir[31:0], 32'h1234_5678);

    // ---------------- rising edge on pin 33 ----------------
    wr(12'h05C, 32'h0);
    wr(12'h060, 32'h2);
    wr(12'h058, 32'h2);
    wr(12'h068, 32'h2);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    gpio_in[33] = 1'b1;
    @(posedge HCLK);                // k
    @(posedge HCLK);                // k+1
    #1;
    check("rise_sync_k1", {31'h0, gpio_in_sync[33]}, 32'h1);
    check("rise_irq_k1",  {31'h0, interrupt}, 32'h0);
    @(posedge HCLK);                // k+2
    #1;
    check("rise_irq_k2",  {31'h0, interrupt}, 32'h1);
    check("rise_bank_k2", {30'h0, irq_bank}, 32'h2);
    rd_chk("rise_status", 12'h064, 32'h2);

    // W1C coinciding with a new rising edge: the set wins
    @(negedge HCLK);
    gpio_in[33] = 1'b0;
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    gpio_in[33] = 1'b1;             // event lands on the W1C write edge
    wr(12'h064, 32'h2);
    rd_chk("w1c_race_status", 12'h064, 32'h2);
    check("w1c_race_irq", {31'h0, interrupt}, 32'h1);
    wr(12'h064, 32'h2);
    check("w1c_clr_irq", {31'h0, interrupt}, 32'h0);
    rd_chk("w1c_clr_status", 12'h064, 32'h0);

    // ---------------- level-low on pin 0 ----------------
    wr(12'h01C, 32'h1);
    wr(12'h018, 32'h1);
    wr(12'h028, 32'h1);
    repeat (2) @(posedge HCLK);
    #1;
    check("lvl_irq_bank", {30'h0, irq_bank}, 32'h1);
    wr(12'h024, 32'h1);
    rd_chk("lvl_reset_status", 12'h024, 32'h1);
    @(negedge HCLK);
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge HCLK);
    wr(12'h024, 32'h1);
    rd_chk("lvl_clr_status", 12'h024, 32'h0);
    rd_chk("lvl_in_reg", 12'h004, 32'h1);
    #1;
    check("lvl_irq_off", {29'h0, irq_bank, interrupt}, 32'h0);

    // ---------------- reset asserted mid-write ----------------
    @(negedge HCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 12'h008;
    bus.PWDATA  = 32'h0000_FFFF;
    @(negedge HCLK);
    bus.PENABLE = 1'b1;
    #2;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    check("mid_rst_out", gpio_out[31:0], 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("mid_rst_out_reg", 12'h008, 32'h0);
    rd_chk("mid_rst_dir1",    12'h040, 32'h0);
    check("mid_rst_sync", {gpio_in_sync[39:32], gpio_in_sync[23:0]}, 32'h0);
    check("mid_rst_dir_pins", {24'h0, gpio_dir[39:32]}, 32'h0);

`ifdef APB_GPIO_BANKED_DEBOUNCE_EN
    // ---------------- debounce ----------------
    @(negedge HCLK);
    gpio_in[0] = 1'b0;
    wr(12'h028, 32'h1);
    wr(12'h030, 32'h3);
    wr(12'h02C, 32'h1);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge HCLK);
    gpio_in[0] = 1'b0;
    repeat (12) @(negedge HCLK);
    check("db_glitch", {31'h0, gpio_in_sync[0]}, 32'h0);
    gpio_in[0] = 1'b1;
    repeat (16) @(negedge HCLK);
    check("db_hold", {31'h0, gpio_in_sync[0]}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
